sad_disparity_selector: RTL and testbench
=========================================

# sad_disparity_selector

Winner-take-all stage directly downstream of the combinational 3x3 SAD (sum of absolute differences) unit in the stereo-matching AXI peripheral. It accepts one SAD value per candidate disparity over a ready/valid stream and tracks the minimum across `MAX_DISPARITY` candidates. When the pixel is complete, it emits the winning disparity index and its SAD. The output is consumed by the result write-back logic.

## Interface
Parameters:
- `SAD_BITS`, 11, width of incoming SAD value; matches the SAD unit's `summation_steps_bits`.
- `MAX_DISPARITY`, 16, candidates per pixel, legal range 2..64.
- `DISP_BITS`, 6, width of disparity index; must satisfy 2^DISP_BITS >= MAX_DISPARITY.

Ports:
- `S_AXI_ACLK`  in  1  sole clock; all logic on rising edge.
- `S_AXI_ARESETN`  in  1  reset, asynchronous assert, active-low.
- `sad_valid`  in  1  `sad_in`/`sad_first` valid.
- `sad_ready`  out  1  stage can accept a SAD beat.
- `sad_in`  in  SAD_BITS  SAD for the current candidate disparity.
- `sad_first`  in  1  beat is candidate 0 of a new pixel.
- `disp_valid`  out  1  result held on `disp_out`/`disp_sad`.
- `disp_ready`  in  1  consumer accepts result.
- `disp_out`  out  DISP_BITS  winning disparity index.
- `disp_sad`  out  SAD_BITS  SAD of winning candidate.
- `resync_err`  out  1  sticky: a pixel was aborted by a mid-pixel `sad_first`.

## Operation
- A beat is accepted when `sad_valid && sad_ready` on a rising edge.
- FSM states:
  - IDLE: `sad_ready`=1. An accepted beat starts a pixel regardless of `sad_first`: best_sad←sad_in, best_idx←0, idx←1, go to ACCUM. With MAX_DISPARITY candidates counted, ACCUM always follows.
  - ACCUM: `sad_ready`=1.
    - Accepted beat with `sad_first`=0: if sad_in < best_sad (strict), best_sad←sad_in and best_idx←idx; then idx←idx+1.
    - Accepted beat with `sad_first`=1: current pixel discarded, `resync_err`←1, and the beat is treated as candidate 0 of a new pixel, as in IDLE.
    - When the accepted beat is candidate index MAX_DISPARITY-1: the comparison includes that beat, results are registered into `disp_out`/`disp_sad`, `disp_valid`←1, go to HOLD.
  - HOLD: `sad_ready`=0; outputs stable. On `disp_ready`=1: `disp_valid`←0, go to IDLE.
- Tie rule: on equal SAD the lower disparity index wins, so the first minimum is kept.
- Comparison is unsigned over SAD_BITS; no saturation or arithmetic is needed.
- `resync_err` is cleared only by reset.

## Timing
- Reset values (async, immediate):
  - state=IDLE, idx=0, best_sad=all ones, best_idx=0.
  - `disp_valid`=0, `disp_out`=0, `disp_sad`=0, `resync_err`=0.
  - `sad_ready`=1 after reset is released; it is combinational from state.
- Reset mid-pixel or in HOLD drops all partial and held results. No output is produced for that pixel.
- Latency: `disp_valid` rises on the clock edge that accepts the last candidate, i.e. visible 1 cycle after that beat is presented.
- Throughput:
  - One beat per cycle in IDLE/ACCUM.
  - Minimum pixel period is MAX_DISPARITY+1 cycles: one HOLD cycle with immediate `disp_ready`, and no bypass from HOLD to ACCUM.
- Outputs `disp_out`, `disp_sad`, `disp_valid` are registered. They remain stable while `disp_valid`=1 and `disp_ready`=0.
- `sad_valid` beats presented in HOLD are not accepted. The upstream producer must hold them, per ready/valid rules.
- `disp_ready` while `disp_valid`=0 is ignored.

## Test plan
Parameters MAX_DISPARITY=4, DISP_BITS=2, SAD_BITS=11 unless noted.
- Monotone minimum: SADs 40,30,20,10 back-to-back, `disp_ready`=1 → `disp_valid` 1 cycle after the 4th beat, `disp_out`=3, `disp_sad`=10; next pixel accepted 2 cycles after the 4th beat.
- Tie and first-wins: 7,3,3,9 → `disp_out`=1, `disp_sad`=3. All 2047 → `disp_out`=0, `disp_sad`=2047.
- Backpressure: 5,1,8,6 with `disp_ready`=0 for 10 cycles → `sad_ready`=0 and `disp_out`=1, `disp_sad`=1 stable throughout. Next pixel's first beat is accepted only after the `disp_ready` cycle.
- Resync:
  - Sequence: 9,2 then a beat 50 with `sad_first`=1, then 40,30,60.
  - Required response: `resync_err`=1, result `disp_out`=2, `disp_sad`=30, and only one result is emitted.
- Async reset: assert `S_AXI_ARESETN`=0 mid-clock during ACCUM (after 2 beats) and during HOLD.
  - All outputs are 0 immediately.
  - A subsequent full pixel 4,3,2,1 yields `disp_out`=3, `disp_sad`=1.
- Default parameters (16 candidates): SAD = |k-11|*3 for k=0..15 → `disp_out`=11, `disp_sad`=0.

Source files
------------

// File: rtl/sad_disparity_selector.sv
// Winner-take-all disparity selector: tracks the minimum SAD over MAX_DISPARITY
// candidates per pixel and holds the winning index/SAD until the consumer accepts.
module sad_disparity_selector #(
  parameter int SAD_BITS      = 11,
  parameter int MAX_DISPARITY = 16,
  parameter int DISP_BITS     = 6
) (
  input  logic                 S_AXI_ACLK,
  input  logic                 S_AXI_ARESETN,
  input  logic                 sad_valid,
  output logic                 sad_ready,
  input  logic [SAD_BITS-1:0]  sad_in,
  input  logic                 sad_first,
  output logic                 disp_valid,
  input  logic                 disp_ready,
  output logic [DISP_BITS-1:0] disp_out,
  output logic [SAD_BITS-1:0]  disp_sad,
  output logic                 resync_err
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  localparam logic [DISP_BITS-1:0] LAST_IDX = DISP_BITS'(MAX_DISPARITY - 1);

  state_t               state, next_state;
  logic [DISP_BITS-1:0] idx;
  logic [DISP_BITS-1:0] best_idx;
  logic [SAD_BITS-1:0]  best_sad;
  logic                 accept, restart, step, last, better;

  // A beat opens a new pixel in IDLE, or in ACCUM when it carries sad_first.
  always_comb begin
    accept  = sad_valid && sad_ready;
    restart = accept && ((state == IDLE) || sad_first);
    step    = accept && (state == ACCUM) && !sad_first;
    last    = step && (idx == LAST_IDX);
    better  = sad_in < best_sad;
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) state <= IDLE;
    else                state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept)     next_state = ACCUM;
      ACCUM:   if (last)       next_state = HOLD;
      HOLD:    if (disp_ready) next_state = IDLE;
      default:                 next_state = IDLE;
    endcase
  end

  always_comb begin
    sad_ready = (state != HOLD);
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      idx        <= '0;
      best_sad   <= '1;
      best_idx   <= '0;
      disp_valid <= 1'b0;
      disp_out   <= '0;
      disp_sad   <= '0;
      resync_err <= 1'b0;
    end else begin
      if (restart) begin
        best_sad <= sad_in;
        best_idx <= '0;
        idx      <= DISP_BITS'(1);
        if (state == ACCUM) resync_err <= 1'b1;
      end else if (step) begin
        if (better) begin
          best_sad <= sad_in;
          best_idx <= idx;
        end
        idx <= idx + 1'b1;
        // The final candidate is folded into the result directly, not via best_*.
        if (last) begin
          disp_valid <= 1'b1;
          disp_out   <= better ? idx    : best_idx;
          disp_sad   <= better ? sad_in : best_sad;
        end
      end
      if ((state == HOLD) && disp_ready) disp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sad_disparity_selector.sv
// Directed bench for sad_disparity_selector: a 4-candidate instance for most
// scenarios and a default 16-candidate instance, checked against a result queue.
module tb_sad_disparity_selector;

  logic clk;
  logic rst_n;

  logic        sad_valid4, sad_first4, disp_ready4;
  logic [10:0] sad_in4;
  logic        sad_ready4, disp_valid4, resync_err4;
  logic [1:0]  disp_out4;
  logic [10:0] disp_sad4;

  logic        sad_valid16, sad_first16, disp_ready16;
  logic [10:0] sad_in16;
  logic        sad_ready16, disp_valid16, resync_err16;
  logic [5:0]  disp_out16;
  logic [10:0] disp_sad16;

  typedef struct {
    int disp;
    int sad;
  } result_t;

  result_t exp_q[$];
  int checks  = 0;
  int errors  = 0;
  int results4 = 0;

  sad_disparity_selector #(.SAD_BITS(11), .MAX_DISPARITY(4), .DISP_BITS(2)) dut4 (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .sad_valid(sad_valid4), .sad_ready(sad_ready4), .sad_in(sad_in4), .sad_first(sad_first4),
    .disp_valid(disp_valid4), .disp_ready(disp_ready4), .disp_out(disp_out4),
    .disp_sad(disp_sad4), .resync_err(resync_err4)
  );

  sad_disparity_selector #(.SAD_BITS(11), .MAX_DISPARITY(16), .DISP_BITS(6)) dut16 (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .sad_valid(sad_valid16), .sad_ready(sad_ready16), .sad_in(sad_in16), .sad_first(sad_first16),
    .disp_valid(disp_valid16), .disp_ready(disp_ready16), .disp_out(disp_out16),
    .disp_sad(disp_sad16), .resync_err(resync_err16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (disp_valid4 && disp_ready4) results4 <= results4 + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the beat was accepted.
  task automatic beat4(input logic [10:0] s, input logic f);
    int n = 0;
    sad_in4    = s;
    sad_first4 = f;
    sad_valid4 = 1'b1;
    while (!sad_ready4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("beat4_timeout", 32'(sad_ready4), 32'd1);
    @(negedge clk);
    sad_valid4 = 1'b0;
    sad_first4 = 1'b0;
  endtask

  task automatic pixel4(input int a, input int b, input int c, input int d);
    beat4(11'(a), 1'b1);
    beat4(11'(b), 1'b0);
    beat4(11'(c), 1'b0);
    beat4(11'(d), 1'b0);
  endtask

  task automatic expect_result(input int disp, input int sad);
    result_t r;
    r.disp = disp;
    r.sad  = sad;
    exp_q.push_back(r);
  endtask

  task automatic check_result4(input string tag);
    int n = 0;
    result_t r;
    while (!disp_valid4 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 32'(disp_valid4), 32'd1);
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      r = exp_q.pop_front();
      check({tag, "_disp"}, 32'(disp_out4), 32'(r.disp));
      check({tag, "_sad"},  32'(disp_sad4),  32'(r.sad));
    end
  endtask

  initial begin
    int r0;
    result_t r;
    rst_n = 1'b0;
    sad_valid4 = 1'b0; sad_first4 = 1'b0; sad_in4 = '0; disp_ready4 = 1'b1;
    sad_valid16 = 1'b0; sad_first16 = 1'b0; sad_in16 = '0; disp_ready16 = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(disp_valid4), 32'd0);
    check("rst_disp",  32'(disp_out4),   32'd0);
    check("rst_sad",   32'(disp_sad4),   32'd0);
    check("rst_resync", 32'(resync_err4), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(sad_ready4), 32'd1);

    // Monotone minimum, back-to-back, immediate disp_ready.
    expect_result(3, 10);
    pixel4(40, 30, 20, 10);
    check("mono_latency", 32'(disp_valid4), 32'd1);
    check_result4("mono");
    check("mono_hold_ready", 32'(sad_ready4), 32'd0);
    @(negedge clk);
    check("mono_idle_ready", 32'(sad_ready4), 32'd1);
    check("mono_valid_drop", 32'(disp_valid4), 32'd0);

    // Ties keep the first minimum; all-max SADs select candidate 0.
    expect_result(1, 3);
    pixel4(7, 3, 3, 9);
    check_result4("tie");
    @(negedge clk);
    expect_result(0, 2047);
    pixel4(2047, 2047, 2047, 2047);
    check_result4("allmax");
    @(negedge clk);

    // Backpressure: result held stable, next beat waits for the handshake.
    disp_ready4 = 1'b0;
    expect_result(1, 1);
    pixel4(5, 1, 8, 6);
    check_result4("bp");
    r0 = results4;
    sad_valid4 = 1'b1; sad_first4 = 1'b1; sad_in4 = 11'd100;
    for (int i = 0; i < 10; i++) begin
      check("bp_ready",  32'(sad_ready4),  32'd0);
      check("bp_valid",  32'(disp_valid4), 32'd1);
      check("bp_disp",   32'(disp_out4),   32'd1);
      check("bp_sad",    32'(disp_sad4),   32'd1);
      @(negedge clk);
    end
    disp_ready4 = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 32'(disp_valid4), 32'd0);
    check("bp_release_ready", 32'(sad_ready4), 32'd1);
    check("bp_one_result", 32'(results4), 32'(r0 + 1));
    expect_result(3, 25);
    beat4(11'd100, 1'b1);
    beat4(11'd50, 1'b0);
    beat4(11'd75, 1'b0);
    beat4(11'd25, 1'b0);
    check_result4("bp_next");
    @(negedge clk);

    // Mid-pixel sad_first aborts the pixel and restarts it.
    check("resync_clear", 32'(resync_err4), 32'd0);
    r0 = results4;
    expect_result(2, 30);
    beat4(11'd9, 1'b1);
    beat4(11'd2, 1'b0);
    beat4(11'd50, 1'b1);
    check("resync_set", 32'(resync_err4), 32'd1);
    beat4(11'd40, 1'b0);
    beat4(11'd30, 1'b0);
    check("resync_no_early", 32'(disp_valid4), 32'd0);
    beat4(11'd60, 1'b0);
    check_result4("resync");
    @(negedge clk);
    repeat (2) @(negedge clk);
    check("resync_count", 32'(results4), 32'(r0 + 1));
    check("resync_sticky", 32'(resync_err4), 32'd1);

    // Asynchronous reset during ACCUM.
    beat4(11'd4, 1'b1);
    beat4(11'd3, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_accum_valid",  32'(disp_valid4), 32'd0);
    check("arst_accum_disp",   32'(disp_out4),   32'd0);
    check("arst_accum_sad",    32'(disp_sad4),   32'd0);
    check("arst_accum_resync", 32'(resync_err4), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Asynchronous reset during HOLD.
    disp_ready4 = 1'b0;
    pixel4(8, 8, 8, 8);
    check("arst_hold_pre", 32'(disp_valid4), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_hold_valid", 32'(disp_valid4), 32'd0);
    check("arst_hold_disp",  32'(disp_out4),   32'd0);
    check("arst_hold_sad",   32'(disp_sad4),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    disp_ready4 = 1'b1;
    @(negedge clk);
    check("arst_ready", 32'(sad_ready4), 32'd1);
    expect_result(3, 1);
    pixel4(4, 3, 2, 1);
    check_result4("post_rst");
    @(negedge clk);

    // Default 16-candidate instance: V-shaped SAD profile with minimum at 11.
    expect_result(11, 0);
    for (int k = 0; k < 16; k++) begin
      sad_valid16 = 1'b1;
      sad_first16 = (k == 0);
      sad_in16    = 11'(((k > 11) ? (k - 11) : (11 - k)) * 3);
      @(negedge clk);
    end
    sad_valid16 = 1'b0;
    sad_first16 = 1'b0;
    check("d16_valid", 32'(disp_valid16), 32'd1);
    if (exp_q.size() == 0) begin
      check("d16_queue", 32'd0, 32'd1);
    end else begin
      r = exp_q.pop_front();
      check("d16_disp", 32'(disp_out16), 32'(r.disp));
      check("d16_sad",  32'(disp_sad16), 32'(r.sad));
    end
    check("d16_resync", 32'(resync_err16), 32'd0);
    @(negedge clk);
    check("d16_valid_drop", 32'(disp_valid16), 32'd0);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
